// File: rtl/program_loader.sv
// Byte-stream program loader: 16-bit big-endian word-count header, then big-endian
// 32-bit words written to program memory. Optional trailing checksum under LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_BASE = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] LP_BASE = 32'(ADDR_BASE);
  localparam logic [31:0] LP_MAX  = 32'(MAX_WORDS);

  state_t      r_state;
  logic [7:0]  r_n_hi;
  logic [15:0] r_n;
  logic [31:0] r_shift;
  logic [1:0]  r_byte_cnt;
  logic [15:0] r_word_count;
  logic [31:0] r_mem_addr;
  logic        r_mem_we;
  logic        r_byte_ready;
  logic        r_cpu_hold;
  logic        r_done;
  logic        r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic [7:0]  w_csum_next;
  assign w_csum_next = r_csum + byte_in;
`endif

  logic        w_accept;
  logic [15:0] w_hdr_n;
  logic [15:0] w_wc_next;

  assign w_accept  = byte_valid & r_byte_ready;
  assign w_hdr_n   = {r_n_hi, byte_in};
  // wc < N whenever WRITE is reached, so wc+1 cannot overflow 16 bits
  assign w_wc_next = r_word_count + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HDR_HI;
      r_n_hi       <= 8'd0;
      r_n          <= 16'd0;
      r_shift      <= 32'd0;
      r_byte_cnt   <= 2'd0;
      r_word_count <= 16'd0;
      r_mem_addr   <= 32'd0;
      r_mem_we     <= 1'b0;
      r_byte_ready <= 1'b1;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      case (r_state)
        HDR_HI: begin
          if (w_accept) begin
            r_n_hi  <= byte_in;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= w_csum_next;
`endif
            r_state <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (w_accept) begin
            r_n <= w_hdr_n;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= w_csum_next;
`endif
            if ({16'd0, w_hdr_n} > LP_MAX) begin
              r_state      <= ERROR;
              r_byte_ready <= 1'b0;
              r_error      <= 1'b1;
            end else if (w_hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state      <= CSUM;
`else
              r_state      <= DONE;
              r_byte_ready <= 1'b0;
              r_cpu_hold   <= 1'b0;
              r_done       <= 1'b1;
`endif
            end else begin
              r_state <= DATA;
            end
          end
        end

        DATA: begin
          if (w_accept) begin
            r_shift    <= {r_shift[23:0], byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= w_csum_next;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_state      <= WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
              r_mem_addr   <= LP_BASE + {16'd0, r_word_count};
            end
          end
        end

        WRITE: begin
          r_mem_we     <= 1'b0;
          r_word_count <= w_wc_next;
          if (w_wc_next < r_n) begin
            r_state      <= DATA;
            r_byte_ready <= 1'b1;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            r_state      <= CSUM;
            r_byte_ready <= 1'b1;
`else
            r_state      <= DONE;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b1;
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (w_accept) begin
            r_byte_ready <= 1'b0;
            if (byte_in == r_csum) begin
              r_state    <= DONE;
              r_cpu_hold <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= ERROR;
              r_error    <= 1'b1;
            end
          end
        end
`endif

        default: begin
          // DONE and ERROR are terminal until reset
          r_state <= r_state;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_shift;
  assign mem_we     = r_mem_we;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued with stimulus,
// popped by a write monitor. Honours LOADER_CHECKSUM_EN by appending the checksum byte.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_pass  = 0;
  int  n_total = 0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_data !== mon_e.data)
          $display("FAIL write: got addr %h data %h, required addr %h data %h",
                   mem_addr, mem_data, mon_e.addr, mon_e.data);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) begin
      n_total++;
      $display("FAIL send_timeout: byte_ready got %b, required 1 for byte %h", byte_ready, b);
    end else begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int stall);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (stall == 1) idle(1);
      else if (stall == 2) idle($urandom_range(0, 2));
    end
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] s[$]);
    logic [7:0] acc = 8'd0;
    foreach (s[i]) acc = acc + s[i];
    return acc;
  endfunction

  task automatic send_tail(input logic [7:0] s[$]);
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum8(s));
`else
    if (s.size() == 0) idle(0);
`endif
  endtask

  task automatic wait_end();
    int w = 0;
    while (done !== 1'b1 && error !== 1'b1 && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (byte_ready !== 1'b1) $display("FAIL rst_ready: got %b, required 1", byte_ready); else n_pass++;
    n_total++; if (cpu_hold !== 1'b1) $display("FAIL rst_hold: got %b, required 1", cpu_hold); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b, required 0", done); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL rst_error: got %b, required 0", error); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b, required 0", mem_we); else n_pass++;
    n_total++; if (word_count !== 16'd0) $display("FAIL rst_wc: got %0d, required 0", word_count); else n_pass++;
  endtask

  task automatic test_basic(input int stall);
    logic [7:0] s[$] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    exp_q.push_back('{addr: 32'd0, data: 32'h11223344});
    exp_q.push_back('{addr: 32'd1, data: 32'hAABBCCDD});
    send_seq(s, stall);
    send_tail(s);
    wait_end();
    idle(1);
    n_total++; if (exp_q.size() != 0) $display("FAIL basic%0d_writes: got %0d pending, required 0", stall, exp_q.size()); else n_pass++;
    n_total++; if (word_count !== 16'd2) $display("FAIL basic%0d_wc: got %0d, required 2", stall, word_count); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL basic%0d_done: got %b, required 1", stall, done); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL basic%0d_hold: got %b, required 0", stall, cpu_hold); else n_pass++;
    n_total++; if (error !== 1'b0) $display("FAIL basic%0d_error: got %b, required 0", stall, error); else n_pass++;
    n_total++; if (byte_ready !== 1'b0) $display("FAIL basic%0d_ready: got %b, required 0", stall, byte_ready); else n_pass++;
  endtask

  task automatic test_done_ignores();
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    idle(5);
    byte_valid = 1'b0;
    n_total++; if (done !== 1'b1) $display("FAIL done_stays: got %b, required 1", done); else n_pass++;
    n_total++; if (word_count !== 16'd2) $display("FAIL done_wc: got %0d, required 2", word_count); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL done_hold: got %b, required 0", cpu_hold); else n_pass++;
  endtask

  task automatic test_header_bounds();
    do_reset();
    send_byte(8'h04);
    send_byte(8'h00);
    n_total++; if (error !== 1'b0) $display("FAIL max_ok_error: got %b, required 0", error); else n_pass++;
    n_total++; if (byte_ready !== 1'b1) $display("FAIL max_ok_ready: got %b, required 1", byte_ready); else n_pass++;
    do_reset();
    send_byte(8'h04);
    send_byte(8'h01);
    n_total++; if (error !== 1'b1) $display("FAIL over_error: got %b, required 1", error); else n_pass++;
    n_total++; if (cpu_hold !== 1'b1) $display("FAIL over_hold: got %b, required 1", cpu_hold); else n_pass++;
    n_total++; if (byte_ready !== 1'b0) $display("FAIL over_ready: got %b, required 0", byte_ready); else n_pass++;
    byte_in    = 8'h00;
    byte_valid = 1'b1;
    idle(6);
    byte_valid = 1'b0;
    n_total++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL over_stays: got error %b done %b, required 1 0", error, done); else n_pass++;
    n_total++; if (word_count !== 16'd0) $display("FAIL over_wc: got %0d, required 0", word_count); else n_pass++;
  endtask

  task automatic test_zero_words();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    n_total++; if (byte_ready !== 1'b1 || done !== 1'b0) $display("FAIL zero_csum_wait: got ready %b done %b, required 1 0", byte_ready, done); else n_pass++;
    send_byte(8'h00);
`endif
    n_total++; if (done !== 1'b1) $display("FAIL zero_done: got %b, required 1", done); else n_pass++;
    n_total++; if (cpu_hold !== 1'b0) $display("FAIL zero_hold: got %b, required 0", cpu_hold); else n_pass++;
    n_total++; if (word_count !== 16'd0) $display("FAIL zero_wc: got %0d, required 0", word_count); else n_pass++;
  endtask

  task automatic test_midload_reset();
    logic [7:0] s[$] = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    do_reset();
    n_total++; if (word_count !== 16'd0 || byte_ready !== 1'b1) $display("FAIL mid_rst: got wc %0d ready %b, required 0 1", word_count, byte_ready); else n_pass++;
    exp_q.push_back('{addr: 32'd0, data: 32'hDEADBEEF});
    send_seq(s, 0);
    send_tail(s);
    wait_end();
    idle(1);
    n_total++; if (exp_q.size() != 0) $display("FAIL mid_writes: got %0d pending, required 0", exp_q.size()); else n_pass++;
    n_total++; if (word_count !== 16'd1) $display("FAIL mid_wc: got %0d, required 1", word_count); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL mid_done: got %b, required 1", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    logic [31:0] w;
    do_reset();
    s.push_back(8'h00);
    s.push_back(8'h05);
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      s.push_back(w[31:24]);
      s.push_back(w[23:16]);
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
      exp_q.push_back('{addr: 32'(k), data: w});
    end
    send_seq(s, 2);
    send_tail(s);
    wait_end();
    idle(1);
    n_total++; if (exp_q.size() != 0) $display("FAIL b2b_writes: got %0d pending, required 0", exp_q.size()); else n_pass++;
    n_total++; if (word_count !== 16'd5) $display("FAIL b2b_wc: got %0d, required 5", word_count); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL b2b_done: got %b, required 1", done); else n_pass++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    exp_q.push_back('{addr: 32'd0, data: 32'h01020304});
    send_seq('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
    send_byte(8'h0B);
    wait_end();
    n_total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL csum_good: got done %b error %b, required 1 0", done, error); else n_pass++;
    do_reset();
    exp_q.push_back('{addr: 32'd0, data: 32'h01020304});
    send_seq('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04}, 0);
    send_byte(8'h0C);
    wait_end();
    n_total++; if (error !== 1'b1 || done !== 1'b0) $display("FAIL csum_bad: got done %b error %b, required 0 1", done, error); else n_pass++;
    n_total++; if (word_count !== 16'd1 || cpu_hold !== 1'b1) $display("FAIL csum_bad_state: got wc %0d hold %b, required 1 1", word_count, cpu_hold); else n_pass++;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    test_reset();
    test_basic(0);
    test_done_ignores();
    test_basic(1);
    test_header_bounds();
    test_zero_words();
    test_midload_reset();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
